round_sequencer: RTL and testbench

Game-level controller for the Precision Button Press datapath. It runs a fixed number of rounds. Each round it latches a pseudo-random 8-bit target pattern onto LEDS, opens a timed response window, and captures SW on the player's BTN press. It then grades the capture against the target, keeps a saturating score and round count, and raises GAME_OVER after the last round. It sits between the board I/O (debounced buttons, switches, LEDs) and the display/score logic.

---
 rtl/round_sequencer.sv | 156 +++++++++++++++
 tb/tb_round_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round controller for the Precision Button Press game: shows an LFSR target,
// times the response window, grades the player's guess and keeps score.
module round_sequencer #(
    parameter int          ROUND_TICKS = 100_000_000,
    parameter int          SHOW_TICKS  = 50_000_000,
    parameter int          ROUNDS      = 8,
    parameter logic [7:0]  SEED        = 8'hA5,
    localparam int         TW          = $clog2(ROUND_TICKS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          BTN,
    input  logic [7:0]    SW,
    output logic [7:0]    LEDS,
    output logic [3:0]    SCORE,
    output logic [3:0]    ROUND,
    output logic [TW-1:0] TIME_LEFT,
    output logic          HIT,
    output logic          MISS,
    output logic          GAME_OVER,
    output logic [2:0]    STATE
);

    localparam int CW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_SHOW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [7:0]    leds_n, lfsr, guess, guess_n;
    logic [3:0]    score_n, round_n;
    logic [TW-1:0] time_n;
    logic          hit_n, miss_n, over_n;
    logic          st_q, bt_q, start_press, btn_press;
    logic [CW-1:0] cnt, cnt_n;

    assign start_press = START & ~st_q;
    assign btn_press   = BTN & ~bt_q;
    assign STATE       = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            LEDS      <= '0;
            SCORE     <= '0;
            ROUND     <= '0;
            TIME_LEFT <= '0;
            HIT       <= 1'b0;
            MISS      <= 1'b0;
            GAME_OVER <= 1'b0;
            lfsr      <= SEED;
            st_q      <= 1'b0;
            bt_q      <= 1'b0;
            guess     <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            LEDS      <= leds_n;
            SCORE     <= score_n;
            ROUND     <= round_n;
            TIME_LEFT <= time_n;
            HIT       <= hit_n;
            MISS      <= miss_n;
            GAME_OVER <= over_n;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            st_q      <= START;
            bt_q      <= BTN;
            guess     <= guess_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        leds_n  = LEDS;
        score_n = SCORE;
        round_n = ROUND;
        time_n  = TIME_LEFT;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        over_n  = GAME_OVER;
        guess_n = guess;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                leds_n = '0;
                if (start_press) begin
                    state_n = S_LOAD;
                    score_n = '0;
                    round_n = '0;
                    over_n  = 1'b0;
                end
            end
            S_LOAD: begin
                leds_n  = lfsr;
                time_n  = TW'(ROUND_TICKS - 1);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // a press on the final window cycle still counts as a press
                if (btn_press) begin
                    guess_n = SW;
                    state_n = S_CHECK;
                end else if (TIME_LEFT == '0) begin
                    miss_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_SHOW;
                end else begin
                    time_n = TIME_LEFT - 1'b1;
                end
            end
            S_CHECK: begin
                if (guess == LEDS) begin
                    hit_n   = 1'b1;
                    score_n = (SCORE == 4'd15) ? SCORE : SCORE + 4'd1;
                end else begin
                    miss_n = 1'b1;
                end
                cnt_n   = '0;
                state_n = S_SHOW;
            end
            S_SHOW: begin
                if (cnt == CW'(SHOW_TICKS - 1)) begin
                    round_n = ROUND + 4'd1;
                    if ({1'b0, ROUND} + 5'd1 == 5'(ROUNDS)) begin
                        state_n = S_DONE;
                        over_n  = 1'b1;
                        leds_n  = {4'b0, SCORE};
                    end else begin
                        state_n = S_LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                leds_n = {4'b0, SCORE};
                if (start_press) begin
                    state_n = S_LOAD;
                    score_n = '0;
                    round_n = '0;
                    over_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed-random bench for round_sequencer: a timeline model predicts the
// target pattern, window, grading and score of every round.
module tb_round_sequencer;

    localparam int RT = 6;
    localparam int ST = 2;
    localparam int NR = 15;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       BTN = 1'b0;
    logic [7:0] SW = 8'h00;
    logic [7:0] LEDS;
    logic [3:0] SCORE, ROUND;
    logic [2:0] TIME_LEFT;
    logic       HIT, MISS, GAME_OVER;
    logic [2:0] STATE;

    int errors = 0;
    int checks = 0;
    logic [7:0] mlfsr;
    int exp_score, exp_round;

    round_sequencer #(
        .ROUND_TICKS(RT), .SHOW_TICKS(ST), .ROUNDS(NR), .SEED(8'hA5)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .BTN(BTN), .SW(SW),
        .LEDS(LEDS), .SCORE(SCORE), .ROUND(ROUND), .TIME_LEFT(TIME_LEFT),
        .HIT(HIT), .MISS(MISS), .GAME_OVER(GAME_OVER), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge; the model LFSR advances with it
    task automatic tick();
        @(posedge CLK);
        mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        chk("rst_state", STATE, 0);
        chk("rst_leds", LEDS, 0);
        chk("rst_score", SCORE, 0);
        chk("rst_round", ROUND, 0);
        chk("rst_time", TIME_LEFT, 0);
        chk("rst_hit", HIT, 0);
        chk("rst_miss", MISS, 0);
        chk("rst_over", GAME_OVER, 0);
        mlfsr = 8'hA5;
        exp_score = 0;
        exp_round = 0;
        RST = 1'b0;
        #1;
    endtask

    task automatic start_game(input bit with_btn);
        START = 1'b1;
        BTN = with_btn;
        tick();
        START = 1'b0;
        BTN = 1'b0;
        exp_score = 0;
        exp_round = 0;
        chk("start_state", STATE, 1);
        chk("start_score", SCORE, 0);
        chk("start_round", ROUND, 0);
        chk("start_over", GAME_OVER, 0);
    endtask

    // mode 0: correct press, 1: wrong press, 2: no press (timeout)
    task automatic play_round(input int mode, input int delay, input bit keep);
        logic [7:0] tgt;
        bit exp_hit;
        tgt = mlfsr;
        tick();
        chk("load_state", STATE, 2);
        chk("load_leds", LEDS, tgt);
        chk("load_time", TIME_LEFT, RT - 1);
        if (mode != 2) begin
            repeat (delay) tick();
            chk("wait_time", TIME_LEFT, RT - 1 - delay);
            SW = (mode == 0) ? tgt : tgt ^ (8'h01 << $urandom_range(0, 7));
            BTN = 1'b1;
            tick();
            chk("press_state", STATE, 3);
            if (!keep) BTN = 1'b0;
            tick();
        end else begin
            repeat (RT - 1) tick();
            chk("to_state", STATE, 2);
            chk("to_time", TIME_LEFT, 0);
            tick();
        end
        exp_hit = (mode == 0);
        if (exp_hit && exp_score < 15) exp_score++;
        chk("show_state", STATE, 4);
        chk("show_hit", HIT, exp_hit);
        chk("show_miss", MISS, !exp_hit);
        chk("show_score", SCORE, exp_score);
        chk("show_leds", LEDS, tgt);
        repeat (ST - 1) begin
            tick();
            chk("show_state2", STATE, 4);
            chk("pulse_hit", HIT, 0);
            chk("pulse_miss", MISS, 0);
        end
        tick();
        exp_round++;
        chk("end_round", ROUND, exp_round);
        if (exp_round == NR) begin
            chk("done_state", STATE, 5);
            chk("done_over", GAME_OVER, 1);
            chk("done_leds", LEDS, exp_score);
        end else begin
            chk("next_state", STATE, 1);
            chk("next_over", GAME_OVER, 0);
        end
    endtask

    initial begin
        logic [7:0] tgt;
        #6;
        do_reset();

        BTN = 1'b1;
        tick();
        BTN = 1'b0;
        tick();
        chk("idle_btn", STATE, 0);
        chk("idle_leds", LEDS, 0);

        start_game(0);
        play_round(0, $urandom_range(0, RT - 2), 0);
        play_round(2, 0, 0);
        play_round(1, $urandom_range(0, RT - 1), 0);
        play_round(0, RT - 1, 0);

        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("mid_wait", STATE, 2);
        do_reset();
        tick();
        chk("post_rst", STATE, 0);

        start_game(0);
        play_round(0, 1, 1);
        play_round(2, 0, 0);
        play_round(2, 0, 0);
        BTN = 1'b0;
        for (int r = 3; r < NR; r++)
            play_round($urandom_range(0, 2), $urandom_range(0, RT - 1), 0);

        BTN = 1'b1;
        tick();
        BTN = 1'b0;
        tick();
        chk("done_btn", STATE, 5);

        start_game(1);
        for (int r = 0; r < NR; r++)
            play_round(0, $urandom_range(0, RT - 1), 0);
        chk("sat_score", SCORE, 15);
        chk("sat_round", ROUND, 15);

        start_game(0);
        tgt = mlfsr;
        tick();
        chk("new_pattern", LEDS, tgt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
